// File: rtl/cdc_hs_pkg.sv
`timescale 1ns/1ps
// Shared FSM state type, default parameters and id-width helper for the clk_a -> clk_b handshake arbiter.
package cdc_hs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_SYNC_STAGES = 2;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdc_bit_sync.sv
`timescale 1ns/1ps
// Single-bit STAGES-flop synchronizer; latency STAGES destination edges, no backpressure.
module cdc_bit_sync
  import cdc_hs_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic arst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) ff <= '0;
    else         ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/cdc_hs_arbiter.sv
`timescale 1ns/1ps
// Arbitrates NUM_REQ clk_a requesters (round-robin; fixed priority with CDC_HS_ARB_FIXED_PRIO_EN) and moves one payload per
// 4-phase req/ack handshake to clk_b, valid SYNC_STAGES+1 clk_b edges after grant; no new grant until the ack has returned.
module cdc_hs_arbiter
  import cdc_hs_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                      i_clk_a,
  input  logic                      i_clk_b,
  input  logic                      i_rst,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ*DATA_W-1:0] i_data,
  output logic [NUM_REQ-1:0]        o_gnt,
  output logic                      o_busy,
  output logic [DATA_W-1:0]         o_data_clk_b,
  output logic [id_w(NUM_REQ)-1:0]  o_src_id_clk_b,
  output logic                      o_valid_clk_b
);

  localparam int ID_W = id_w(NUM_REQ);

  state_t             state;
  state_t             state_nxt;
  logic               req_a;
  logic               req_a_nxt;
  logic               ack_a;
  logic               req_b;
  logic               ack_b;
  logic               take;
  logic [ID_W-1:0]    win;
  logic [DATA_W-1:0]  win_data;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] gnt_nxt;
  logic [DATA_W-1:0]  hold_data;
  logic [ID_W-1:0]    hold_id;
  logic               rise_b;

`ifdef CDC_HS_ARB_FIXED_PRIO_EN
  always_comb begin
    win = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_req[i]) win = ID_W'(i);
    end
  end
`else
  logic [ID_W-1:0] ptr;

  // Search begins just past the last winner and wraps, so every requester is reached within NUM_REQ grants.
  always_comb begin
    logic            found;
    logic [ID_W-1:0] idx;
    found = 1'b0;
    idx   = '0;
    win   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && i_req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_ff @(posedge i_clk_a or negedge i_rst) begin
    if (!i_rst)    ptr <= ID_W'(NUM_REQ - 1);
    else if (take) ptr <= win;
  end
`endif

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == ID_W'(i)) win_data = i_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_nxt = state;
    req_a_nxt = req_a;
    gnt_nxt   = '0;
    take      = 1'b0;
    case (state)
      IDLE: begin
        if (|i_req) begin
          state_nxt = REQ;
          req_a_nxt = 1'b1;
          gnt_nxt   = NUM_REQ'(1) << win;
          take      = 1'b1;
        end
      end
      REQ: begin
        if (ack_a) begin
          state_nxt = ACK;
          req_a_nxt = 1'b0;
        end
      end
      ACK: begin
        if (!ack_a) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        req_a_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk_a or negedge i_rst) begin
    if (!i_rst) begin
      state     <= IDLE;
      req_a     <= 1'b0;
      gnt       <= '0;
      hold_data <= '0;
      hold_id   <= '0;
    end else begin
      state <= state_nxt;
      req_a <= req_a_nxt;
      gnt   <= gnt_nxt;
      if (take) begin
        hold_data <= win_data;
        hold_id   <= win;
      end
    end
  end

  assign o_gnt  = gnt;
  assign o_busy = (state != IDLE);

  cdc_bit_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk    (i_clk_b),
    .arst_n (i_rst),
    .d      (req_a),
    .q      (req_b)
  );

  // ack_b doubles as the previous req_b, so its low-to-high mismatch marks the rising edge.
  assign rise_b = req_b & ~ack_b;

  always_ff @(posedge i_clk_b or negedge i_rst) begin
    if (!i_rst) begin
      ack_b          <= 1'b0;
      o_valid_clk_b  <= 1'b0;
      o_data_clk_b   <= '0;
      o_src_id_clk_b <= '0;
    end else begin
      ack_b         <= req_b;
      o_valid_clk_b <= rise_b;
      if (rise_b) begin
        o_data_clk_b   <= hold_data;
        o_src_id_clk_b <= hold_id;
      end
    end
  end

  cdc_bit_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk    (i_clk_a),
    .arst_n (i_rst),
    .d      (ack_b),
    .q      (ack_a)
  );

endmodule

// File: tb/tb_cdc_hs_arbiter.sv
`timescale 1ns/1ps
// Directed and randomized checks of cdc_hs_arbiter; grants predicted from request vectors, deliveries matched via a scoreboard.
module tb_cdc_hs_arbiter;
  import cdc_hs_pkg::*;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int S  = 2;
  localparam int IW = id_w(N);

  logic           clk_a   = 1'b0;
  logic           clk_b   = 1'b0;
  logic           rst     = 1'b1;
  logic [N-1:0]   req_in  = '0;
  logic [N*W-1:0] data_in = '0;
  logic [N-1:0]   gnt;
  logic           busy;
  logic [W-1:0]   dat_b;
  logic [IW-1:0]  id_b;
  logic           vld_b;

  real half_a = 5.0;
  real half_b = 13.5;

  typedef struct {
    int      pay;
    int      sid;
    realtime t;
  } xfer_t;

  xfer_t sb[$];
  int    id_log[$];
  int    vectors     = 0;
  int    miscompares = 0;
  int    gnt_cnt     = 0;
  int    vld_cnt     = 0;
  int    model_last  = N - 1;
  int    last_data   = 0;
  int    last_id     = 0;
  int    exp_ids[5];

  cdc_hs_arbiter #(.NUM_REQ(N), .DATA_W(W), .SYNC_STAGES(S)) dut (
    .i_clk_a        (clk_a),
    .i_clk_b        (clk_b),
    .i_rst          (rst),
    .i_req          (req_in),
    .i_data         (data_in),
    .o_gnt          (gnt),
    .o_busy         (busy),
    .o_data_clk_b   (dat_b),
    .o_src_id_clk_b (id_b),
    .o_valid_clk_b  (vld_b)
  );

  initial forever #(half_a) clk_a = ~clk_a;
  initial begin
    #1.7;
    forever #(half_b) clk_b = ~clk_b;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int last);
`ifdef CDC_HS_ARB_FIXED_PRIO_EN
    for (int k = 0; k < N; k++) if (r[k]) return k;
`else
    for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
`endif
    return -1;
  endfunction

  // Grant side: an idle arbiter must grant exactly the predicted requester on any edge with requests.
  logic [N-1:0]   cap_req;
  logic [N*W-1:0] cap_data;
  logic           cap_rst;
  realtime        cap_t;
  logic           busy_q = 1'b0;
  int             mw;
  logic [N-1:0]   exp_g;

  always @(posedge clk_a) begin
    cap_req  = req_in;
    cap_data = data_in;
    cap_rst  = rst;
    cap_t    = $realtime;
    #1;
    exp_g = '0;
    mw    = -1;
    if (cap_rst === 1'b1 && busy_q === 1'b0 && cap_req != '0) begin
      mw        = pick(cap_req, model_last);
      exp_g[mw] = 1'b1;
    end
    chk("gnt", 32'(gnt), 32'(exp_g));
    if (mw >= 0) begin
      sb.push_back('{pay: int'(cap_data[mw*W +: W]), sid: mw, t: cap_t});
      model_last = mw;
      gnt_cnt++;
    end
    busy_q = busy;
  end

  // Delivery side: each valid consumes one scoreboard entry and must land SYNC_STAGES+1 clk_b edges after its grant.
  realtime tv;
  xfer_t   ent;
  int      nb;

  always @(posedge clk_b) begin
    tv = $realtime;
    #1;
    if (vld_b === 1'b1) begin
      vld_cnt++;
      last_data = int'(dat_b);
      last_id   = int'(id_b);
      id_log.push_back(int'(id_b));
      chk("sb_nonempty_at_valid", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        ent = sb.pop_front();
        chk("data_b", 32'(dat_b), ent.pay);
        chk("id_b", 32'(id_b), ent.sid);
        nb = 0;
        while (tv - nb * 2.0 * half_b > ent.t + 0.01) nb++;
        chk("latency_b_edges", nb, S + 1);
      end
    end
  end

  task automatic wait_grants(input int target, input int budget);
    int n = 0;
    while (gnt_cnt < target && n < budget) begin
      @(negedge clk_a);
      n++;
    end
    chk("grant_within_budget", 32'(gnt_cnt >= target), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk_a);
      n++;
    end
    chk("idle_within_budget", 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk_a);
    rst = 1'b0;
    sb.delete();
    model_last = N - 1;
    @(negedge clk_a);
    rst = 1'b1;
  endtask

  task automatic run_random(input int n, input int budget);
    int g0 = gnt_cnt;
    int v0 = vld_cnt;
    int c  = 0;
    while (gnt_cnt - g0 < n && c < budget) begin
      @(negedge clk_a);
      req_in = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      for (int k = 0; k < N; k++) data_in[k*W +: W] = W'($urandom);
      c++;
    end
    req_in = '0;
    chk("rand_grant_count", gnt_cnt - g0, n);
    wait_idle(budget);
    chk("rand_valid_eq_grant", vld_cnt - v0, gnt_cnt - g0);
    chk("rand_sb_empty", sb.size(), 0);
  endtask

  initial begin
    int g0;
    int v0;
`ifdef CDC_HS_ARB_FIXED_PRIO_EN
    exp_ids = '{0, 0, 0, 0, 0};
`else
    exp_ids = '{0, 1, 2, 3, 0};
`endif
    #0.5 rst = 1'b0;
    #20;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(vld_b), 0);
    chk("rst_data", 32'(dat_b), 0);
    chk("rst_id", 32'(id_b), 0);
    @(negedge clk_a);
    rst = 1'b1;

    // Single request from requester 0.
    req_in          = 4'b0001;
    data_in[7:0]    = 8'hA5;
    g0              = gnt_cnt;
    v0              = vld_cnt;
    wait_grants(g0 + 1, 50);
    req_in = '0;
    chk("t1_busy_after_gnt", 32'(busy), 1);
    wait_idle(2000);
    chk("t1_valid_before_idle", vld_cnt - v0, 1);
    chk("t1_grant_count", gnt_cnt - g0, 1);
    chk("t1_data", last_data, 8'hA5);
    chk("t1_id", last_id, 0);

    // All requesters held: rotation order from reset.
    do_reset();
    id_log.delete();
    for (int k = 0; k < N; k++) data_in[k*W +: W] = W'(8'h10 + k);
    req_in = 4'b1111;
    wait_grants(gnt_cnt + 5, 3000);
    req_in = '0;
    wait_idle(2000);
    chk("t2_valid_count", id_log.size(), 5);
    for (int k = 0; k < 5; k++)
      chk("t2_id_order", (k < id_log.size()) ? id_log[k] : -1, exp_ids[k]);

    // Payload changes after grant must not reach clk_b.
    req_in             = 4'b0100;
    data_in[2*W +: W]  = 8'h3C;
    wait_grants(gnt_cnt + 1, 50);
    data_in[2*W +: W]  = 8'hFF;
    req_in             = '0;
    wait_idle(2000);
    chk("t3_data", last_data, 8'h3C);
    chk("t3_id", last_id, 2);

    // Outputs hold between transfers, then reset aborts an in-flight transfer.
    repeat (20) @(negedge clk_a);
    chk("t4_hold_data", 32'(dat_b), 8'h3C);
    chk("t4_hold_id", 32'(id_b), 2);
    req_in        = 4'b0001;
    data_in[7:0]  = 8'h5A;
    v0            = vld_cnt;
    wait_grants(gnt_cnt + 1, 50);
    chk("t4_busy_in_req", 32'(busy), 1);
    #2;
    rst = 1'b0;
    sb.delete();
    model_last = N - 1;
    #1;
    chk("t4_rst_gnt", 32'(gnt), 0);
    chk("t4_rst_busy", 32'(busy), 0);
    chk("t4_rst_valid", 32'(vld_b), 0);
    chk("t4_rst_data", 32'(dat_b), 0);
    chk("t4_rst_id", 32'(id_b), 0);
    req_in            = 4'b0010;
    data_in[1*W +: W] = 8'h77;
    repeat (30) @(negedge clk_a);
    chk("t4_no_valid_in_reset", vld_cnt - v0, 0);
    rst = 1'b1;
    wait_grants(gnt_cnt + 1, 1);
    req_in = '0;
    wait_idle(2000);
    chk("t4_one_valid_after_release", vld_cnt - v0, 1);
    chk("t4_new_data", last_data, 8'h77);
    chk("t4_new_id", last_id, 1);

    // Random traffic with clk_b 7x slower, then 7x faster.
    half_a = 5.0;
    half_b = 35.0;
    repeat (20) @(negedge clk_a);
    run_random(100, 30000);
    half_a = 35.0;
    half_b = 5.0;
    repeat (20) @(negedge clk_a);
    run_random(100, 30000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
